// File: rtl/cmd_frame_pkg.sv
// Shared command codes and controller state encoding for the command-frame controller.
package cmd_frame_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;   // RF write: AA, addr, data
    localparam logic [7:0] CMD_RD     = 8'hBB;   // RF read: BB, addr
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;   // ALU with operands: CC, opA, opB, fun
    localparam logic [7:0] CMD_ALU    = 8'hDD;   // ALU without operands: DD, fun

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OPA,
        ST_OPB,
        ST_FUN,
        ST_ALU_WAIT,
        ST_PUSH
    } state_e;

endpackage

// File: rtl/cmd_frame_tx_push.sv
// Result serialiser: shifts a captured result out to the TX FIFO one DATA_W beat
// at a time, least-significant first, stalling while the FIFO reports full.
module cmd_frame_tx_push #(
    parameter int DATA_W    = 8,
    parameter int ALU_OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,    // capture data_i this cycle
    input  logic                 single_i,  // with load_i: push one beat instead of NBEATS
    input  logic [ALU_OUT_W-1:0] data_i,
    input  logic                 full_i,
    output logic [DATA_W-1:0]    wr_data_o,
    output logic                 wr_inc_o,
    output logic                 done_o     // last beat is being pushed this cycle
);

    localparam int NBEATS = ALU_OUT_W / DATA_W;
    localparam int CNT_W  = $clog2(NBEATS + 1);

    logic [ALU_OUT_W-1:0] shreg_q, shreg_d, src;
    logic [CNT_W-1:0]     cnt_q, cnt_d, remaining;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 wr_inc_q, wr_inc_d;
    logic                 fire;

    // The loading cycle may already push its first beat, giving one-cycle latency
    // from the result strobe to the first FIFO write.
    always_comb begin
        src       = load_i ? data_i : shreg_q;
        remaining = load_i ? (single_i ? CNT_W'(1) : CNT_W'(NBEATS)) : cnt_q;
        fire      = (remaining != '0) && !full_i;
        done_o    = fire && (remaining == CNT_W'(1));
        shreg_d   = src;
        cnt_d     = remaining;
        wr_inc_d  = 1'b0;
        wr_data_d = wr_data_q;
        if (fire) begin
            wr_inc_d  = 1'b1;
            wr_data_d = src[DATA_W-1:0];
            shreg_d   = src >> DATA_W;
            cnt_d     = remaining - CNT_W'(1);
        end
    end

    // Shift register, beat counter and registered FIFO strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            wr_data_q <= '0;
            wr_inc_q  <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            wr_inc_q  <= wr_inc_d;
        end
    end

    assign wr_data_o = wr_data_q;
    assign wr_inc_o  = wr_inc_q;

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes RX byte frames into register-file writes/reads
// and ALU operations, returns results to the TX FIFO, and flags bad or stalled frames.
module cmd_frame_ctrl
    import cmd_frame_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int FUN_W     = 4,
    parameter int ALU_OUT_W = 16,
    parameter int TIMEOUT   = 4096,
    parameter int OPA_ADDR  = 0,
    parameter int OPB_ADDR  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_W-1:0]    RX_P_DATA,
    input  logic                 RX_D_VLD,
    input  logic [DATA_W-1:0]    RdData,
    input  logic                 RdData_valid,
    input  logic [ALU_OUT_W-1:0] ALU_OUT,
    input  logic                 OUT_valid,
    input  logic                 FIFO_FULL,
    output logic [ADDR_W-1:0]    Address,
    output logic                 WrEN,
    output logic [DATA_W-1:0]    WrData,
    output logic                 RdEN,
    output logic                 ALU_EN,
    output logic [FUN_W-1:0]     ALU_FUN,
    output logic                 CLKG_EN,
    output logic [DATA_W-1:0]    WR_DATA_FIFO,
    output logic                 WR_INC,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               rx_acc, wake, counting, tmo_abort;
    logic               push_load, push_single, push_done;
    logic [ALU_OUT_W-1:0] push_data;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wrdata_q, wrdata_d;
    logic [FUN_W-1:0]   fun_q, fun_d;
    logic               wren_q, wren_d, rden_q, rden_d, aluen_q, aluen_d;
    logic               clkg_q, clkg_d, err_q, err_d, busy_q, busy_d;

    // Per-state event decode: byte acceptance, wake-up event and timeout expiry.
    always_comb begin
        rx_acc   = 1'b0;
        wake     = 1'b0;
        counting = 1'b1;
        unique case (state_q)
            ST_IDLE:     begin rx_acc = RX_D_VLD; counting = 1'b0; end
            ST_RD_WAIT:  wake = RdData_valid;
            ST_ALU_WAIT: wake = OUT_valid;
            ST_PUSH:     counting = 1'b0;
            default:     rx_acc = RX_D_VLD;
        endcase
        if (state_q != ST_IDLE && rx_acc) wake = 1'b1;
        // A wake event in the expiry cycle wins over the timeout.
        tmo_abort = counting && !wake && (TIMEOUT != 0)
                    && (tmo_q == TMO_W'(TIMEOUT - 1));
        push_load   = wake && (state_q == ST_RD_WAIT || state_q == ST_ALU_WAIT);
        push_single = (state_q == ST_RD_WAIT);
        push_data   = push_single ? ALU_OUT_W'(RdData) : ALU_OUT;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (tmo_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (rx_acc) begin
                    if (RX_P_DATA == DATA_W'(CMD_WR))          state_d = ST_WR_ADDR;
                    else if (RX_P_DATA == DATA_W'(CMD_RD))     state_d = ST_RD_ADDR;
                    else if (RX_P_DATA == DATA_W'(CMD_ALU_OP)) state_d = ST_OPA;
                    else if (RX_P_DATA == DATA_W'(CMD_ALU))    state_d = ST_FUN;
                end
                ST_WR_ADDR:  if (rx_acc) state_d = ST_WR_DATA;
                ST_WR_DATA:  if (rx_acc) state_d = ST_IDLE;
                ST_RD_ADDR:  if (rx_acc) state_d = ST_RD_WAIT;
                ST_OPA:      if (rx_acc) state_d = ST_OPB;
                ST_OPB:      if (rx_acc) state_d = ST_FUN;
                ST_FUN:      if (rx_acc) state_d = ST_ALU_WAIT;
                // A result that fits in one unstalled beat completes immediately.
                ST_RD_WAIT, ST_ALU_WAIT:
                    if (wake) state_d = push_done ? ST_IDLE : ST_PUSH;
                ST_PUSH:     if (push_done) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Output next-values: latched address/data/function and one-cycle strobes.
    always_comb begin
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        fun_d    = fun_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        aluen_d  = 1'b0;
        err_d    = tmo_abort;
        if (rx_acc) begin
            unique case (state_q)
                ST_IDLE:    err_d = (state_d == ST_IDLE);
                ST_WR_ADDR: addr_d = RX_P_DATA[ADDR_W-1:0];
                ST_WR_DATA: begin wrdata_d = RX_P_DATA; wren_d = 1'b1; end
                ST_RD_ADDR: begin addr_d = RX_P_DATA[ADDR_W-1:0]; rden_d = 1'b1; end
                ST_OPA: begin
                    addr_d = ADDR_W'(OPA_ADDR); wrdata_d = RX_P_DATA; wren_d = 1'b1;
                end
                ST_OPB: begin
                    addr_d = ADDR_W'(OPB_ADDR); wrdata_d = RX_P_DATA; wren_d = 1'b1;
                end
                ST_FUN:     begin fun_d = RX_P_DATA[FUN_W-1:0]; aluen_d = 1'b1; end
                default:    ;
            endcase
        end
        // Clock gate opens on an ALU command and stays open until the frame ends.
        clkg_d = clkg_q ? (state_d != ST_IDLE)
                        : (state_q == ST_IDLE && rx_acc
                           && (RX_P_DATA == DATA_W'(CMD_ALU_OP)
                               || RX_P_DATA == DATA_W'(CMD_ALU)));
        busy_d = (state_d != ST_IDLE);
    end

    // Timeout counter: cleared on state change or accepted byte, runs in waiting states.
    always_comb begin
        if (state_d != state_q || rx_acc || !counting) tmo_d = '0;
        else                                            tmo_d = tmo_q + TMO_W'(1);
    end

    // Output and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            fun_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            aluen_q  <= 1'b0;
            clkg_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            fun_q    <= fun_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            aluen_q  <= aluen_d;
            clkg_q   <= clkg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    cmd_frame_tx_push #(
        .DATA_W    (DATA_W),
        .ALU_OUT_W (ALU_OUT_W)
    ) u_push (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (push_load),
        .single_i  (push_single),
        .data_i    (push_data),
        .full_i    (FIFO_FULL),
        .wr_data_o (WR_DATA_FIFO),
        .wr_inc_o  (WR_INC),
        .done_o    (push_done)
    );

    assign Address   = addr_q;
    assign WrEN      = wren_q;
    assign WrData    = wrdata_q;
    assign RdEN      = rden_q;
    assign ALU_EN    = aluen_q;
    assign ALU_FUN   = fun_q;
    assign CLKG_EN   = clkg_q;
    assign FRAME_ERR = err_q;
    assign BUSY      = busy_q;

endmodule
